// File: rtl/pin_loopback_checker_pkg.sv
// Shared definitions for the pin loopback checker: FSM state encoding and the
// saturating counter step used by the per-pin edge/mismatch counters.
package pin_loopback_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int SAT_W = 32;

    // Callers widen their counter to SAT_W and pass their own all-ones ceiling.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] vmax,
                                                 input logic             en);
        if (en && (v != vmax)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pin_loopback_checker_sync2.sv
// Two-flop synchronizer for one asynchronous input; both flops clear to 0 on reset.
module pin_loopback_checker_sync2
    import pin_loopback_checker_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pin_loopback_checker.sv
// Receive side of the bring-up loopback pattern: counts per-pin edges and cycles
// disagreeing with the synchronized reference, then grades each pin after a window.
module pin_loopback_checker
    import pin_loopback_checker_pkg::*;
#(
    parameter int NPINS     = 16,
    parameter int WINDOW    = 65536,
    parameter int SETTLE    = 4,
    parameter int CNT_W     = 16,
    parameter int MIN_EDGES = 2,
    parameter int MAX_MISM  = 0
) (
    input  logic                       clk_12mhz,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       ref_in,
    input  logic [NPINS-1:0]           pin_in,
    output logic                       busy,
    output logic                       done,
    output logic [NPINS-1:0]           pin_ok,
    // One spare index bit so that out-of-range selects can be expressed.
    input  logic [$clog2(NPINS+1)-1:0] rd_sel,
    output logic [CNT_W-1:0]           rd_edges,
    output logic [CNT_W-1:0]           rd_mism
);

    localparam int SEL_W   = $clog2(NPINS + 1);
    localparam int CYC_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);
    localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WINDOW - 1);
    localparam logic [SAT_W-1:0] CNT_MAX     = SAT_W'({CNT_W{1'b1}});

    logic             rst_meta_q;
    logic             rst_sync_n_q;
    state_e           state_q;
    logic [CYC_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [NPINS-1:0] pin_ok_q;
    logic [NPINS-1:0] ok_d;
    logic             ref_s;
    logic             accept;
    logic             meas;
    logic             win_end;
    logic [CNT_W-1:0] edges_a [NPINS];
    logic [CNT_W-1:0] mism_a  [NPINS];

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    pin_loopback_checker_sync2 u_ref_sync (
        .clk_i  (clk_12mhz),
        .rst_ni (rst_sync_n_q),
        .d_i    (ref_in),
        .q_o    (ref_s)
    );

    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign meas    = (state_q == ST_MEASURE);
    assign win_end = meas && (cnt_q == WIN_LAST);

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        logic             pin_s;
        logic             prev_q;
        logic [CNT_W-1:0] edges_q;
        logic [CNT_W-1:0] mism_q;
        logic [CNT_W-1:0] edges_d;
        logic [CNT_W-1:0] mism_d;

        pin_loopback_checker_sync2 u_pin_sync (
            .clk_i  (clk_12mhz),
            .rst_ni (rst_sync_n_q),
            .d_i    (pin_in[i]),
            .q_o    (pin_s)
        );

        assign edges_d = CNT_W'(sat_inc(SAT_W'(edges_q), CNT_MAX, meas && (pin_s != prev_q)));
        assign mism_d  = CNT_W'(sat_inc(SAT_W'(mism_q), CNT_MAX, meas && (pin_s != ref_s)));

        // Graded from the next-state counts so the final window cycle is included.
        assign ok_d[i] = (32'(edges_d) >= MIN_EDGES) && (32'(mism_d) <= MAX_MISM);

        always_ff @(posedge clk_12mhz or negedge rst_sync_n_q) begin
            if (!rst_sync_n_q) begin
                prev_q  <= 1'b0;
                edges_q <= '0;
                mism_q  <= '0;
            end else begin
                prev_q <= pin_s;
                if (accept) begin
                    edges_q <= '0;
                    mism_q  <= '0;
                end else if (meas) begin
                    edges_q <= edges_d;
                    mism_q  <= mism_d;
                end
            end
        end

        assign edges_a[i] = edges_q;
        assign mism_a[i]  = mism_q;
    end

    always_ff @(posedge clk_12mhz or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pin_ok_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_SETTLE;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pin_ok_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_MEASURE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (win_end) begin
                        state_q  <= ST_DONE;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pin_ok_q <= ok_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign pin_ok = pin_ok_q;

    always_comb begin
        rd_edges = '0;
        rd_mism  = '0;
        for (int i = 0; i < NPINS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_edges = edges_a[i];
                rd_mism  = mism_a[i];
            end
        end
    end

endmodule
